// File: rtl/calc_result_decoder_pkg.sv
// Shared definitions for the calculator result decoder: FSM states, BCD
// correction constants and an elaboration-time helper.
package calc_result_decoder_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } state_e;

    localparam logic [3:0] BcdAdjLim = 4'd5;
    localparam logic [3:0] BcdAdjAdd = 4'd3;

    function automatic longint unsigned pow10(input int unsigned n);
        longint unsigned r;
        r = 64'd1;
        for (int unsigned i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/calc_result_decoder_bcd_adj3.sv
// Double-dabble digit correction: a digit of 5 or more gets 3 added so that
// the following left shift carries correctly into the next decade.
module calc_result_decoder_bcd_adj3
    import calc_result_decoder_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    always_comb begin
        digit_o = digit_i;
        if (digit_i >= BcdAdjLim) begin
            digit_o = digit_i + BcdAdjAdd;
        end
    end

endmodule

// File: rtl/calc_result_decoder.sv
// Converts a signed W-bit result into sign + packed BCD magnitude using a
// sequential shift/add-3 conversion, with valid/ready on both sides.
module calc_result_decoder
    import calc_result_decoder_pkg::*;
#(
    parameter int unsigned W    = 6,
    parameter int unsigned NDIG = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [W-1:0]      in_data_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    output logic              out_sign_o,
    output logic [4*NDIG-1:0] out_bcd_o,
    output logic              out_zero_o,
    output logic              out_valid_o,
    input  logic              out_ready_i
);

    localparam int unsigned CntW = $clog2(W + 1);
    localparam int unsigned BcdW = 4 * NDIG;

    // The most negative input has magnitude 2^(W-1); the digits must hold it.
    if (pow10(NDIG) <= (64'd1 << (W - 1))) begin : g_width_check
        $error("calc_result_decoder: NDIG too small for W");
    end

    state_e            state_q, state_d;
    logic              sign_q, sign_d;
    logic [W-1:0]      mag_q, mag_d;
    logic [BcdW-1:0]   bcd_q, bcd_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              out_valid_q, out_valid_d;
    logic              out_sign_q, out_sign_d;
    logic              out_zero_q, out_zero_d;
    logic [BcdW-1:0]   out_bcd_q, out_bcd_d;

    logic [W-1:0]      in_mag;
    logic [BcdW-1:0]   bcd_adj;
    logic [BcdW-1:0]   bcd_shift;

    for (genvar i = 0; i < NDIG; i++) begin : g_adj
        calc_result_decoder_bcd_adj3 u_adj (
            .digit_i (bcd_q[4*i +: 4]),
            .digit_o (bcd_adj[4*i +: 4])
        );
    end

    // Two's-complement negate wraps -2^(W-1) onto itself, which read as
    // unsigned is exactly the wanted magnitude.
    assign in_mag    = in_data_i[W-1] ? (~in_data_i + W'(1)) : in_data_i;
    assign bcd_shift = {bcd_adj[BcdW-2:0], mag_q[W-1]};

    always_comb begin
        state_d     = state_q;
        sign_d      = sign_q;
        mag_d       = mag_q;
        bcd_d       = bcd_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_sign_d  = out_sign_q;
        out_zero_d  = out_zero_q;
        out_bcd_d   = out_bcd_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid_i) begin
                    sign_d  = in_data_i[W-1];
                    mag_d   = in_mag;
                    bcd_d   = '0;
                    cnt_d   = CntW'(W);
                    state_d = StShift;
                end
            end
            StShift: begin
                bcd_d = bcd_shift;
                mag_d = {mag_q[W-2:0], 1'b0};
                cnt_d = cnt_q - CntW'(1);
                // Outputs load on the final shift so they are valid on DONE entry.
                if (cnt_q == CntW'(1)) begin
                    state_d     = StDone;
                    out_valid_d = 1'b1;
                    out_bcd_d   = bcd_shift;
                    out_zero_d  = (bcd_shift == '0);
                    out_sign_d  = sign_q & (bcd_shift != '0);
                end
            end
            StDone: begin
                if (out_ready_i) begin
                    state_d     = StIdle;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            sign_q      <= 1'b0;
            mag_q       <= '0;
            bcd_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_sign_q  <= 1'b0;
            out_zero_q  <= 1'b0;
            out_bcd_q   <= '0;
        end else begin
            state_q     <= state_d;
            sign_q      <= sign_d;
            mag_q       <= mag_d;
            bcd_q       <= bcd_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_sign_q  <= out_sign_d;
            out_zero_q  <= out_zero_d;
            out_bcd_q   <= out_bcd_d;
        end
    end

    assign in_ready_o  = (state_q == StIdle);
    assign out_valid_o = out_valid_q;
    assign out_sign_o  = out_sign_q;
    assign out_zero_o  = out_zero_q;
    assign out_bcd_o   = out_bcd_q;

endmodule

// File: tb/tb_calc_result_decoder.sv
// Directed and exhaustive checks of the signed-to-BCD result decoder.
module tb_calc_result_decoder;

    logic       clk;
    logic       rst_n;
    logic [5:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       out_sign;
    logic [7:0] out_bcd;
    logic       out_zero;
    logic       out_valid;
    logic       out_ready;

    int n_chk;
    int n_bad;

    calc_result_decoder #(
        .W    (6),
        .NDIG (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_data_i   (in_data),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .out_sign_o  (out_sign),
        .out_bcd_o   (out_bcd),
        .out_zero_o  (out_zero),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    function automatic logic [7:0] model_bcd(input int v);
        int m;
        m = (v < 0) ? -v : v;
        return {4'(m / 10), 4'(m % 10)};
    endfunction

    // Called #1 after a rising edge. Returns edges from accept (inclusive)
    // until out_valid is seen high.
    task automatic run_word(input logic [5:0] d, input logic rdy, output int lat);
        int guard;
        out_ready = rdy;
        in_data   = d;
        in_valid  = 1'b1;
        guard     = 0;
        while (!in_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = ~d;
        lat      = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic check_word(input string tag, input int v, input int lat);
        chk($sformatf("%s lat", tag), lat, 7);
        chk($sformatf("%s valid", tag), out_valid, 1);
        chk($sformatf("%s bcd", tag), out_bcd, model_bcd(v));
        chk($sformatf("%s sign", tag), out_sign, (v < 0) ? 1 : 0);
        chk($sformatf("%s zero", tag), out_zero, (v == 0) ? 1 : 0);
    endtask

    task automatic word_handoff(input string tag, input int v);
        int lat;
        run_word(6'(v), 1'b1, lat);
        check_word(tag, v, lat);
        @(posedge clk); #1;
        chk($sformatf("%s drop", tag), out_valid, 0);
        chk($sformatf("%s rdy", tag), in_ready, 1);
    endtask

    initial begin
        int lat;
        int seen;
        logic [7:0] held;

        n_chk     = 0;
        n_bad     = 0;
        rst_n     = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #2;
        chk("rst in_ready", in_ready, 1);
        chk("rst out_valid", out_valid, 0);
        chk("rst out_sign", out_sign, 0);
        chk("rst out_bcd", out_bcd, 0);
        chk("rst out_zero", out_zero, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Hand-computed vectors
        run_word(6'sd15, 1'b1, lat);
        chk("p15 lat", lat, 7);
        chk("p15 bcd", out_bcd, 8'h15);
        chk("p15 sign", out_sign, 0);
        chk("p15 zero", out_zero, 0);
        @(posedge clk); #1;
        run_word(6'b110001, 1'b1, lat);
        chk("m15 bcd", out_bcd, 8'h15);
        chk("m15 sign", out_sign, 1);
        @(posedge clk); #1;
        run_word(6'b100000, 1'b1, lat);
        chk("m32 bcd", out_bcd, 8'h32);
        chk("m32 sign", out_sign, 1);
        @(posedge clk); #1;
        run_word(6'sd31, 1'b1, lat);
        chk("p31 bcd", out_bcd, 8'h31);
        chk("p31 sign", out_sign, 0);
        @(posedge clk); #1;
        run_word(6'd0, 1'b1, lat);
        chk("z bcd", out_bcd, 8'h00);
        chk("z sign", out_sign, 0);
        chk("z zero", out_zero, 1);
        @(posedge clk); #1;

        // Backpressure: hold for 5 cycles while stray in_valid pulses arrive
        run_word(6'b101110, 1'b0, lat);
        check_word("bp", -18, lat);
        held = out_bcd;
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0];
            in_data  = 6'sd3;
            @(posedge clk); #1;
            chk($sformatf("bp hold valid %0d", i), out_valid, 1);
            chk($sformatf("bp hold bcd %0d", i), out_bcd, held);
            chk($sformatf("bp hold sign %0d", i), out_sign, 1);
            chk($sformatf("bp in_ready %0d", i), in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp drop", out_valid, 0);
        chk("bp rdy", in_ready, 1);

        // Back-to-back stream
        word_handoff("s7", 7);
        word_handoff("sm1", -1);
        word_handoff("sm9", -9);

        // Exhaustive sweep
        for (int v = -32; v < 32; v++) begin
            word_handoff($sformatf("ex%0d", v), v);
        end

        // Reset during the third shift cycle
        in_data  = 6'sd20;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("ar in_ready", in_ready, 1);
        chk("ar out_valid", out_valid, 0);
        chk("ar out_bcd", out_bcd, 0);
        chk("ar out_sign", out_sign, 0);
        chk("ar out_zero", out_zero, 0);
        @(negedge clk); rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("ar no stale", seen, 0);
        word_handoff("ar next", -20);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
